// File: rtl/stopwatch_counter_if.sv
// Control levels from the stopwatch fsm and the counter outputs feeding the display driver.
// The counter is the slave; the fsm/display side (or a bench) is the master.
interface stopwatch_counter_if;
    logic       one_run_push;
    logic       ten_run_push;
    logic       pause_push;
    logic       clear_push;
    logic       step;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    modport master (
        output one_run_push, ten_run_push, pause_push, clear_push,
        input  step, sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );

    modport slave (
        input  one_run_push, ten_run_push, pause_push, clear_push,
        output step, sec_ones, sec_tens, min_ones, min_tens, running, wrap
    );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch counter with a shared prescaler for 1x and 10x count rates.
// Mode levels are prioritised clear > pause > ten > one > idle on every rising edge.
module stopwatch_counter #(
    parameter  int CLK_DIV = 100,
    localparam int PRE_W   = $clog2(CLK_DIV)
) (
    input  logic               clk,
    input  logic               n_rst,
    stopwatch_counter_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_IDLE,
        MODE_ONE,
        MODE_TEN,
        MODE_PAUSE,
        MODE_CLEAR
    } mode_e;

    localparam logic [PRE_W-1:0] LIM_1X_M1  = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] LIM_10X_M1 = PRE_W'(CLK_DIV / 10 - 1);

    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic             r_step, r_running, r_wrap;

    mode_e            w_mode;
    logic [PRE_W-1:0] w_limit_m1;
    logic             w_hit;
    logic [3:0]       w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
    logic             w_rollover;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        w_mode = MODE_IDLE;
        if (bus.clear_push)        w_mode = MODE_CLEAR;
        else if (bus.pause_push)   w_mode = MODE_PAUSE;
        else if (bus.ten_run_push) w_mode = MODE_TEN;
        else if (bus.one_run_push) w_mode = MODE_ONE;

        w_limit_m1 = (w_mode == MODE_TEN) ? LIM_10X_M1 : LIM_1X_M1;
        // >= rather than == so a 1x->10x switch mid-interval steps on the next edge.
        w_hit      = (r_pre >= w_limit_m1);
    end

    // Next count value: ripple carry through the four BCD digits.
    always_comb begin
        w_sec_ones = r_sec_ones;
        w_sec_tens = r_sec_tens;
        w_min_ones = r_min_ones;
        w_min_tens = r_min_tens;
        w_rollover = 1'b0;
        if (r_sec_ones != 4'd9) begin
            w_sec_ones = r_sec_ones + 4'd1;
        end else begin
            w_sec_ones = 4'd0;
            if (r_sec_tens != 4'd5) begin
                w_sec_tens = r_sec_tens + 4'd1;
            end else begin
                w_sec_tens = 4'd0;
                if (r_min_ones != 4'd9) begin
                    w_min_ones = r_min_ones + 4'd1;
                end else begin
                    w_min_ones = 4'd0;
                    if (r_min_tens != 4'd9) begin
                        w_min_tens = r_min_tens + 4'd1;
                    end else begin
                        w_min_tens = 4'd0;
                        w_rollover = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pre      <= '0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_step     <= 1'b0;
            r_running  <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_step    <= 1'b0;
            r_running <= (w_mode == MODE_ONE) || (w_mode == MODE_TEN);
            case (w_mode)
                MODE_CLEAR: begin
                    r_pre      <= '0;
                    r_sec_ones <= 4'd0;
                    r_sec_tens <= 4'd0;
                    r_min_ones <= 4'd0;
                    r_min_tens <= 4'd0;
                    r_wrap     <= 1'b0;
                end
                MODE_ONE, MODE_TEN: begin
                    if (w_hit) begin
                        r_pre      <= '0;
                        r_step     <= 1'b1;
                        r_sec_ones <= w_sec_ones;
                        r_sec_tens <= w_sec_tens;
                        r_min_ones <= w_min_ones;
                        r_min_tens <= w_min_tens;
                        if (w_rollover) r_wrap <= 1'b1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.step     = r_step;
    assign bus.sec_ones = r_sec_ones;
    assign bus.sec_tens = r_sec_tens;
    assign bus.min_ones = r_min_ones;
    assign bus.min_tens = r_min_tens;
    assign bus.running  = r_running;
    assign bus.wrap     = r_wrap;
endmodule
